// File: rtl/serial_frame_pkg.sv
// ============================================================================
// serial_frame_pkg : shared types and constants for the serial frame transmitter
// Optional parity bit is enabled by defining SERIAL_FRAME_PARITY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_frame_pkg;

`ifdef SERIAL_FRAME_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        DELIM  = 3'd2,
        DATA   = 3'd3,
        STUFF  = 3'd4,
        PARITY = 3'd5
    } state_t;
`else
    localparam bit PARITY_EN = 1'b0;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        DELIM  = 3'd2,
        DATA   = 3'd3,
        STUFF  = 3'd4
    } state_t;
`endif

    localparam logic [1:0] STUFF_RUN = 2'd2;

    function automatic int sync_cnt_w(input int sync_len);
        return (sync_len > 1) ? $clog2(sync_len) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_bit_stuffer.sv
// ============================================================================
// frame_bit_stuffer : ones-run counter that flags when a stuff zero is due
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_bit_stuffer
    import serial_frame_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_bit,        // bit going onto the line next cycle
    input  logic i_clear,      // next line bit is not a payload/parity bit
    output logic o_stuff_due,  // bit currently on the line completes a run
    output logic o_due_next    // bit going out next will complete a run
);

    logic [1:0] r_run;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_run <= 2'd0;
        end else if (i_bit) begin
            r_run <= r_run + 2'd1;
        end else begin
            r_run <= 2'd0;
        end
    end

    assign o_stuff_due = (r_run == STUFF_RUN);
    assign o_due_next  = !i_clear && i_bit && (r_run == (STUFF_RUN - 2'd1));

endmodule

`default_nettype wire

// File: rtl/serial_frame_tx.sv
// ============================================================================
// serial_frame_tx : sync preamble + delimiter + zero-stuffed MSB-first payload
// Define SERIAL_FRAME_PARITY_EN to append an even-parity bit after the payload.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SYNC_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int SYNC_W = sync_cnt_w(SYNC_LEN);
    localparam int BIT_W  = $clog2(DATA_W + 2);
    localparam logic [SYNC_W-1:0] c_sync_last = SYNC_W'(SYNC_LEN - 1);
    localparam logic [BIT_W-1:0]  c_last_bit  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  c_pay_end   = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0]  c_final_cnt = BIT_W'(PARITY_EN ? DATA_W + 1 : DATA_W);
`ifdef SERIAL_FRAME_PARITY_EN
    localparam state_t c_after_payload = PARITY;
`else
    localparam state_t c_after_payload = IDLE;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shreg, w_shreg_nxt;
    logic [BIT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [SYNC_W-1:0]   r_sync_cnt, w_sync_cnt_nxt;
    logic                r_tx, r_busy, r_done;
    logic                w_tx_nxt, w_done_nxt, w_bit_en;
    logic                w_accept, w_stuff_due, w_due_next;
`ifdef SERIAL_FRAME_PARITY_EN
    logic                r_parity, w_parity_nxt;
`endif

    assign in_ready = (r_state == IDLE) && !reset;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_sync_cnt_nxt = r_sync_cnt;
`ifdef SERIAL_FRAME_PARITY_EN
        w_parity_nxt   = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = SYNC;
                    w_shreg_nxt    = in_data;
                    w_bit_cnt_nxt  = '0;
                    w_sync_cnt_nxt = '0;
`ifdef SERIAL_FRAME_PARITY_EN
                    w_parity_nxt   = ^in_data;
`endif
                end
            end
            SYNC: begin
                if (r_sync_cnt == c_sync_last) begin
                    w_state_nxt = DELIM;
                end else begin
                    w_sync_cnt_nxt = r_sync_cnt + 1'b1;
                end
            end
            DELIM: w_state_nxt = DATA;
            DATA: begin
                w_shreg_nxt   = {r_shreg[DATA_W-2:0], 1'b0};
                w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                if (w_stuff_due) begin
                    w_state_nxt = STUFF;
                end else if (r_bit_cnt == c_last_bit) begin
                    w_state_nxt = c_after_payload;
                end
            end
            STUFF: begin
                // Stuffs after the last payload (or parity) bit end the frame
                if (r_bit_cnt < c_pay_end) begin
                    w_state_nxt = DATA;
                end else if (r_bit_cnt == c_pay_end) begin
                    w_state_nxt = c_after_payload;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
`ifdef SERIAL_FRAME_PARITY_EN
            PARITY: begin
                w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                w_state_nxt   = w_stuff_due ? STUFF : IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // Line value for the next cycle, so tx comes straight from a flop
    always_comb begin
        w_tx_nxt = 1'b0;
        w_bit_en = 1'b0;
        case (w_state_nxt)
            SYNC: w_tx_nxt = 1'b1;
            DATA: begin
                w_tx_nxt = w_shreg_nxt[DATA_W-1];
                w_bit_en = 1'b1;
            end
`ifdef SERIAL_FRAME_PARITY_EN
            PARITY: begin
                w_tx_nxt = w_parity_nxt;
                w_bit_en = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            DATA:  w_done_nxt = !PARITY_EN && (w_bit_cnt_nxt == c_last_bit) && !w_due_next;
            STUFF: w_done_nxt = (w_bit_cnt_nxt == c_final_cnt);
`ifdef SERIAL_FRAME_PARITY_EN
            PARITY: w_done_nxt = !w_due_next;
`endif
            default: ;
        endcase
    end

    frame_bit_stuffer u_stuffer (
        .clk         (clk),
        .rst         (reset),
        .i_bit       (w_tx_nxt),
        .i_clear     (!w_bit_en),
        .o_stuff_due (w_stuff_due),
        .o_due_next  (w_due_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_sync_cnt <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= w_done_nxt;
        end
    end

`ifdef SERIAL_FRAME_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// ============================================================================
// tb_serial_frame_tx : directed table-driven bench for serial_frame_tx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_frame_tx;

    localparam int DATA_W   = 8;
    localparam int SYNC_LEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic [31:0] bits;
        int          len;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(DATA_W), .SYNC_LEN(SYNC_LEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int max_run(input logic [31:0] b, input int len, input int skip);
        int run  = 0;
        int best = 0;
        for (int i = len - 1 - skip; i >= 0; i--) begin
            if (i < 32 && b[i]) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
        end
        return best;
    endfunction

    // Called at the negedge of the first frame cycle; returns at the first idle negedge
    task automatic check_frame(input string name, input logic [31:0] exp_bits, input int exp_len);
        logic [31:0] bits = '0;
        int len = 0, done_cnt = 0, done_pos = -1, rdy_hi = 0;
        while (busy === 1'b1 && len < 40) begin
            bits = {bits[30:0], tx};
            if (done) begin
                done_cnt++;
                done_pos = len;
            end
            if (in_ready) rdy_hi++;
            len++;
            @(negedge clk);
        end
        check({name, " bits"},      bits, exp_bits);
        check({name, " length"},    32'(len), 32'(exp_len));
        check({name, " done count"}, 32'(done_cnt), 32'd1);
        check({name, " done pos"},  32'(done_pos), 32'(exp_len - 1));
        check({name, " ready low"}, 32'(rdy_hi), 32'd0);
        check({name, " run>2"},     32'(max_run(bits, len, SYNC_LEN + 1) > 2), 32'd0);
        check({name, " idle"},      {29'd0, tx, in_ready, busy}, 32'b010);
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic [31:0] exp_bits,
                             input int exp_len);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_frame(name, exp_bits, exp_len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int rdy;
        int idle;
        int saw_done;
        logic [31:0] exp_81, exp_01;

`ifdef SERIAL_FRAME_PARITY_EN
        vecs[0] = '{8'hA5, 32'({4'hF, 1'b0, 8'hA5, 1'b0}), 14};
        vecs[1] = '{8'hFF, 32'({4'hF, 1'b0, 12'b1101_1011_0110, 1'b0}), 18};
        vecs[2] = '{8'h02, 32'({4'hF, 1'b0, 8'h02, 1'b1}), 14};
        vecs[3] = '{8'h00, 32'({4'hF, 1'b0, 8'h00, 1'b0}), 14};
        vecs[4] = '{8'h6D, 32'({4'hF, 1'b0, 10'b0110011001, 1'b1, 1'b0}), 17};
        vecs[5] = '{8'h03, 32'({4'hF, 1'b0, 9'b000000110, 1'b0}), 15};
        exp_81  = 32'({4'hF, 1'b0, 8'h81, 1'b0});
        exp_01  = 32'({4'hF, 1'b0, 8'h01, 1'b1, 1'b0});
`else
        vecs[0] = '{8'hA5, 32'({4'hF, 1'b0, 8'hA5}), 13};
        vecs[1] = '{8'hFF, 32'({4'hF, 1'b0, 12'b1101_1011_0110}), 17};
        vecs[2] = '{8'h63, 32'({4'hF, 1'b0, 10'b0110000110}), 15};
        vecs[3] = '{8'h00, 32'({4'hF, 1'b0, 8'h00}), 13};
        vecs[4] = '{8'h6D, 32'({4'hF, 1'b0, 10'b0110011001}), 15};
        vecs[5] = '{8'h03, 32'({4'hF, 1'b0, 9'b000000110}), 14};
        exp_81  = 32'({4'hF, 1'b0, 8'h81});
        exp_01  = 32'({4'hF, 1'b0, 8'h01});
`endif

        // Reset held with a pending word
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        bad = 0;
        rdy = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
            if (in_ready !== 1'b0) rdy++;
        end
        check("reset outputs", 32'(bad), 32'd0);
        check("reset ready", 32'(rdy), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post reset", {29'd0, in_ready, busy, tx}, 32'b100);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("vec%0d_%02h", i, vecs[i].data), vecs[i].data, vecs[i].bits, vecs[i].len);
        end

        // Back-to-back frames with in_valid held high
        in_data  = 8'h81;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h03;
        check_frame("b2b frame1", exp_81, $bits(exp_81) - $countones(1'b0) - 32 + 32 == 32 ? vecs[0].len : 0);
        idle = 0;
        while (busy !== 1'b1 && idle < 10) begin
            check("b2b idle tx", {31'd0, tx}, 32'd0);
            idle++;
            @(negedge clk);
        end
        check("b2b idle cycles", 32'(idle), 32'd1);
        in_valid = 1'b0;
        check_frame("b2b frame2", vecs[5].bits, vecs[5].len);

        // Reset during the third payload cycle of 0xF0
        in_data  = 8'hF0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        saw_done = 0;
        for (int k = 1; k < SYNC_LEN + 4; k++) begin
            if (done) saw_done++;
            @(negedge clk);
        end
        if (done) saw_done++;
        check("abort in frame", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        if (done) saw_done++;
        check("abort outputs", {29'd0, tx, busy, done}, 32'd0);
        check("abort no done", 32'(saw_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort ready", {31'd0, in_ready}, 32'd1);
        run_frame("after abort 01", 8'h01, exp_01, vecs[3].len + ((exp_01 == 32'({4'hF, 1'b0, 8'h01})) ? 0 : 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
